// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: commits traps and erets from M-stage, then flushes and redirects the pipeline.
// Latency: req/exl_clr are combinational in the trigger cycle; flush/redirect follow from the next edge.
// Backpressure: none; inputs are ignored while FLUSH or ERET is active, and pending interrupts stay held by their sources.
module exc_sched #(
   parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic [4:0]  exc_m,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic        eret_m,
   input  logic [5:0]  hwint,
   input  logic [5:0]  sr_im,
   input  logic        sr_ie,
   input  logic        sr_exl,
   input  logic [31:0] epc_in,
   output logic        req,
   output logic [4:0]  exc_code,
   output logic [31:0] epc_out,
   output logic        bd_out,
   output logic        exl_clr,
   output logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic [7:0]  trap_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FLUSH = 2'd1;
   localparam logic [1:0] S_ERET  = 2'd2;

   // Counter reload value; the first FLUSH cycle is the one where the counter still holds it.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] trap_cnt_q, trap_cnt_d;

   logic int_pend;
   logic in_idle;
   logic trig;
   logic take_eret;
   logic first_flush;

   // Trigger decode; everything is gated by reset so outputs read 0 while it is held.
   always_comb begin
      int_pend    = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
      in_idle     = (state_q == S_IDLE) & ~reset;
      trig        = in_idle & m_valid & (int_pend | (exc_m != 5'd0));
      take_eret   = in_idle & m_valid & eret_m & ~trig;
      first_flush = (state_q == S_FLUSH) & (cnt_q == FLUSH_LOAD);
   end

   // CP0 commit outputs: only non-zero in the trap cycle; interrupts take priority over exceptions.
   always_comb begin
      req      = trig;
      exc_code = 5'd0;
      epc_out  = 32'd0;
      bd_out   = 1'b0;
      exl_clr  = take_eret;
      if (trig) begin
         exc_code = int_pend ? 5'd0 : exc_m;
         epc_out  = bd_m ? (pc_m - 32'd4) : pc_m;
         bd_out   = bd_m;
      end
   end

   // Pipeline control outputs: flush in FLUSH/ERET, redirect in first FLUSH cycle or the ERET cycle.
   always_comb begin
      busy        = ~reset & (state_q != S_IDLE);
      flush       = ~reset & ((state_q == S_FLUSH) | (state_q == S_ERET));
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      if (!reset && state_q == S_ERET) begin
         redirect    = 1'b1;
         redirect_pc = epc_in;
      end else if (!reset && first_flush) begin
         redirect    = 1'b1;
         redirect_pc = HANDLER_PC;
      end
      trap_cnt = trap_cnt_q;
   end

   // Next-state logic for the controller, flush down-counter and trap counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      trap_cnt_d = trap_cnt_q + {7'd0, trig};
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d = S_FLUSH;
               cnt_d   = FLUSH_LOAD;
            end else if (take_eret) begin
               state_d = S_ERET;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 3'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_ERET: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         trap_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         trap_cnt_q <= trap_cnt_d;
      end
   end

endmodule

// File: tb/tb_exc_sched.sv
// Scoreboard bench for exc_sched: stimulus pushes hand-computed per-cycle expectations, a negedge monitor pops and compares.
// Latency: one expectation per clock cycle, checked mid-cycle.
// Backpressure: none; the queue must drain completely by the end of the run.
module tb_exc_sched;

   logic        clk;
   logic        reset;
   logic        m_valid;
   logic [4:0]  exc_m;
   logic [31:0] pc_m;
   logic        bd_m;
   logic        eret_m;
   logic [5:0]  hwint;
   logic [5:0]  sr_im;
   logic        sr_ie;
   logic        sr_exl;
   logic [31:0] epc_in;
   logic        req;
   logic [4:0]  exc_code;
   logic [31:0] epc_out;
   logic        bd_out;
   logic        exl_clr;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        busy;
   logic [7:0]  trap_cnt;

   exc_sched dut (
      .clk(clk), .reset(reset), .m_valid(m_valid), .exc_m(exc_m), .pc_m(pc_m),
      .bd_m(bd_m), .eret_m(eret_m), .hwint(hwint), .sr_im(sr_im), .sr_ie(sr_ie),
      .sr_exl(sr_exl), .epc_in(epc_in), .req(req), .exc_code(exc_code),
      .epc_out(epc_out), .bd_out(bd_out), .exl_clr(exl_clr), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .trap_cnt(trap_cnt)
   );

   typedef struct packed {
      logic        req;
      logic [4:0]  code;
      logic [31:0] epc;
      logic        bd;
      logic        exl;
      logic        fl;
      logic        rd;
      logic [31:0] rpc;
      logic        busy;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ex(input logic r, input logic [4:0] c, input logic [31:0] e,
                               input logic b, input logic x, input logic f, input logic d,
                               input logic [31:0] p, input logic bs, input logic [7:0] n);
      exp_t t;
      t.req = r; t.code = c; t.epc = e; t.bd = b; t.exl = x;
      t.fl = f; t.rd = d; t.rpc = p; t.busy = bs; t.cnt = n;
      return t;
   endfunction

   function automatic exp_t idle_e(input logic [7:0] n);
      return ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, n);
   endfunction

   function automatic exp_t fl1(input logic [7:0] n);
      return ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_4180, 1'b1, n);
   endfunction

   function automatic exp_t fl2(input logic [7:0] n);
      return ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, n);
   endfunction

   function automatic exp_t trap_e(input logic [4:0] c, input logic [31:0] e, input logic b,
                                   input logic [7:0] n);
      return ex(1'b1, c, e, b, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, n);
   endfunction

   task automatic drv(input logic v, input logic [4:0] e, input logic [31:0] p,
                      input logic b, input logic r);
      m_valid = v; exc_m = e; pc_m = p; bd_m = b; eret_m = r;
   endtask

   // Queue this cycle's expectation, then advance to just after the next rising edge.
   task automatic step(input exp_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs against the oldest expectation on each falling edge.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         n_cyc++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            a = ex(req, exc_code, epc_out, bd_out, exl_clr, flush, redirect, redirect_pc, busy, trap_cnt);
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL cyc%0d outputs: got req=%b code=%0d epc=%h bd=%b exl=%b fl=%b rd=%b rpc=%h busy=%b cnt=%0d | want req=%b code=%0d epc=%h bd=%b exl=%b fl=%b rd=%b rpc=%h busy=%b cnt=%0d",
                        n_cyc, a.req, a.code, a.epc, a.bd, a.exl, a.fl, a.rd, a.rpc, a.busy, a.cnt,
                        e.req, e.code, e.epc, e.bd, e.exl, e.fl, e.rd, e.rpc, e.busy, e.cnt);
            end
         end
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      reset = 1'b1;
      hwint = 6'd0; sr_im = 6'd0; sr_ie = 1'b0; sr_exl = 1'b0; epc_in = 32'd0;
      drv(1'b1, 5'd4, 32'h3010, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      // Trigger presented while in reset: everything stays 0.
      step(idle_e(8'd0));
      // Release reset with the trigger still present: taken immediately.
      reset = 1'b0;
      step(trap_e(5'd4, 32'h3010, 1'b0, 8'd0));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd1));
      step(fl2(8'd1));
      step(idle_e(8'd1));

      // Delay-slot exception.
      drv(1'b1, 5'd10, 32'h3014, 1'b1, 1'b0);
      step(trap_e(5'd10, 32'h3010, 1'b1, 8'd1));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd2));
      step(fl2(8'd2));
      // Bubble carrying an exception code: no trap.
      drv(1'b0, 5'd7, 32'h3050, 1'b0, 1'b0);
      step(idle_e(8'd2));

      // Interrupt beats exception.
      hwint = 6'b000100; sr_im = 6'b000100; sr_ie = 1'b1; sr_exl = 1'b0;
      drv(1'b1, 5'd12, 32'h3100, 1'b0, 1'b0);
      step(trap_e(5'd0, 32'h3100, 1'b0, 8'd2));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd3));
      step(fl2(8'd3));
      // EXL masks the interrupt, so the exception code goes through.
      sr_exl = 1'b1;
      drv(1'b1, 5'd12, 32'h3104, 1'b0, 1'b0);
      step(trap_e(5'd12, 32'h3104, 1'b0, 8'd3));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd4));
      step(fl2(8'd4));
      // Pending interrupt waits for a valid M instruction.
      sr_exl = 1'b0;
      step(idle_e(8'd4));
      drv(1'b1, 5'd0, 32'h3200, 1'b0, 1'b0);
      step(trap_e(5'd0, 32'h3200, 1'b0, 8'd4));
      hwint = 6'd0;
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd5));
      step(fl2(8'd5));

      // Eret with no trigger; inputs during ERET are ignored.
      epc_in = 32'h3020;
      drv(1'b1, 5'd0, 32'h3204, 1'b0, 1'b1);
      step(ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd5));
      drv(1'b1, 5'd9, 32'h3208, 1'b0, 1'b1);
      step(ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b1, 8'd5));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(idle_e(8'd5));

      // Trap and eret together: trap wins; exception during FLUSH is ignored.
      drv(1'b1, 5'd8, 32'h3300, 1'b0, 1'b1);
      step(trap_e(5'd8, 32'h3300, 1'b0, 8'd5));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd6));
      drv(1'b1, 5'd6, 32'h3304, 1'b0, 1'b0);
      step(fl2(8'd6));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(idle_e(8'd6));

      // Reset in the second FLUSH cycle clears everything mid-cycle.
      drv(1'b1, 5'd4, 32'h3400, 1'b0, 1'b0);
      step(trap_e(5'd4, 32'h3400, 1'b0, 8'd6));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd7));
      reset = 1'b1;
      step(idle_e(8'd0));
      reset = 1'b0;
      step(idle_e(8'd0));

      // 256 back-to-back traps with the exception held during FLUSH: counter wraps to 0.
      drv(1'b1, 5'd1, 32'h5000, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         step(trap_e(5'd1, 32'h5000, 1'b0, 8'(i)));
         step(fl1(8'(i + 1)));
         step(fl2(8'(i + 1)));
      end
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(idle_e(8'd0));

      // Delay-slot EPC wrap-around below zero.
      drv(1'b1, 5'd3, 32'h0000_0002, 1'b1, 1'b0);
      step(trap_e(5'd3, 32'hFFFF_FFFE, 1'b1, 8'd0));
      drv(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      step(fl1(8'd1));
      step(fl2(8'd1));
      step(idle_e(8'd1));

      @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exc_sched.md
EXC_SCHED -- requirements
Module: exc_sched

Interface
REQ-001 SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception handler entry address.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles pipeline flush is held after a trap (range 1..7).
REQ-003 SHALL have ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_valid  in  1  M-stage holds a real instruction (not a bubble).
- exc_m  in  5  M-stage exception code; 0 means none.
- pc_m  in  32  M-stage instruction PC.
- bd_m  in  1  M-stage instruction is in a delay slot.
- eret_m  in  1  M-stage instruction is eret.
- hwint  in  6  hardware interrupt lines.
- sr_im  in  6  CP0 SR interrupt mask.
- sr_ie  in  1  CP0 SR global interrupt enable.
- sr_exl  in  1  CP0 SR exception level.
- epc_in  in  32  current CP0 EPC.
- req  out  1  trap commit strobe to CP0.
- exc_code  out  5  cause code for CP0.
- epc_out  out  32  value CP0 loads into EPC.
- bd_out  out  1  BD bit for CP0.
- exl_clr  out  1  eret commit strobe to CP0.
- flush  out  1  kill all pipeline stages F..M.
- redirect  out  1  next-PC override valid.
- redirect_pc  out  32  next-PC override value.
- busy  out  1  controller not in IDLE.
- trap_cnt  out  8  number of traps taken.

Function
REQ-004 SHALL implement three states: IDLE, FLUSH, ERET.
REQ-005 SHALL compute int_pend = |(hwint & sr_im) & sr_ie & ~sr_exl combinationally.
REQ-006 SHALL, in IDLE with m_valid=1, define trig = int_pend | (exc_m != 0).
REQ-007 SHALL, in IDLE when trig=1, drive req=1 combinationally in that cycle; FLUSH is entered on the next edge.
REQ-008 SHALL give interrupts priority over exceptions: exc_code=0 if int_pend=1, else exc_m.
REQ-009 SHALL drive epc_out = bd_m ? pc_m-4 : pc_m and bd_out=bd_m in the req cycle, with 32-bit wrap-around on the subtraction.
REQ-010 SHALL hold exc_code, epc_out and bd_out at 0 whenever req=0.
REQ-011 SHALL load a down-counter with FLUSH_CYCLES-1 on FLUSH entry.
REQ-012 SHALL assert flush=1 in every FLUSH cycle, and return to IDLE when the counter reaches 0.
REQ-013 SHALL assert redirect=1 with redirect_pc=HANDLER_PC only in the first FLUSH cycle.
REQ-014 SHALL increment trap_cnt by 1 on each req, wrapping from 255 to 0.
REQ-015 SHALL, in IDLE with m_valid=1, eret_m=1 and trig=0, drive exl_clr=1 for that cycle and enter ERET on the next edge.
REQ-016 SHALL, in ERET, drive flush=1, redirect=1 and redirect_pc=epc_in for exactly one cycle, then return to IDLE.
REQ-017 SHALL, when trig=1 and eret_m=1 coincide, take the trap and drop the eret (exl_clr=0).
REQ-018 SHALL, when m_valid=0, not trap; a pending interrupt is held by its sources and taken at the next valid M instruction.
REQ-019 SHALL ignore all trigger and eret inputs while in FLUSH or ERET (req=0, exl_clr=0).
REQ-020 SHALL drive busy=1 in FLUSH and ERET, and busy=0 in IDLE.
REQ-021 SHALL drive redirect_pc=0 whenever redirect=0.

Reset
REQ-022 SHALL, on reset=1, asynchronously force state=IDLE, flush counter=0 and trap_cnt=0.
REQ-023 SHALL, on reset=1, force every output to 0, including during a FLUSH or ERET sequence already in progress.
REQ-024 SHALL, after reset deasserts, accept a trigger on the first rising edge.

Verification
REQ-025 SHALL cover: exc_m=5'd4, pc_m=32'h3010, bd_m=0, m_valid=1 -> req=1, exc_code=4, epc_out=32'h3010; then flush=1 for 2 cycles, redirect_pc=32'h4180 in the first; trap_cnt=1.
REQ-026 SHALL cover: delay slot with bd_m=1, pc_m=32'h3014, exc_m=10 -> epc_out=32'h3010, bd_out=1.
REQ-027 SHALL cover: hwint=6'b000100, sr_im=6'b000100, sr_ie=1, sr_exl=0, exc_m=12 -> exc_code=0; same stimulus with sr_exl=1 -> exc_code=12.
REQ-028 SHALL cover: eret_m=1, epc_in=32'h3020, no trigger -> exl_clr=1; next cycle flush=1, redirect_pc=32'h3020; busy clears the cycle after.
REQ-029 SHALL cover: reset asserted in the second FLUSH cycle -> flush, busy and trap_cnt all 0 immediately, without waiting for a clock edge.
REQ-030 SHALL cover: 256 back-to-back traps -> trap_cnt wraps to 0; an exception presented during FLUSH produces no req.
